// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Counter width for a modulus of v; never returns less than 1 so 1-state counters stay legal
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (64'(v) > (64'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0]       nib_i,
  output logic [SEG_W-1:0] seg_o_c
);

  // Full 0-F decode
  always_comb begin
    seg_o_c = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o_c = SEG_0;
      4'h1: seg_o_c = SEG_1;
      4'h2: seg_o_c = SEG_2;
      4'h3: seg_o_c = SEG_3;
      4'h4: seg_o_c = SEG_4;
      4'h5: seg_o_c = SEG_5;
      4'h6: seg_o_c = SEG_6;
      4'h7: seg_o_c = SEG_7;
      4'h8: seg_o_c = SEG_8;
      4'h9: seg_o_c = SEG_9;
      4'hA: seg_o_c = SEG_A;
      4'hB: seg_o_c = SEG_B;
      4'hC: seg_o_c = SEG_C;
      4'hD: seg_o_c = SEG_D;
      4'hE: seg_o_c = SEG_E;
      4'hF: seg_o_c = SEG_F;
      default: seg_o_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with dead time,
// blink, leading-zero suppression and frame-aligned (tear-free) updates.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD_CYC     = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_on,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_sup,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W = clog2(SCAN_DIV);
  localparam int unsigned IDX_W = clog2(NUM_DIGITS);
  localparam int unsigned FRM_W = clog2(BLINK_FRAMES);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  phase_q, phase_d;

  logic [VAL_W-1:0]      act_val_q, act_val_d, pnd_val_q, pnd_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0] act_on_q, act_on_d, pnd_on_q, pnd_on_d;
  logic [NUM_DIGITS-1:0] act_blk_q, act_blk_d, pnd_blk_q, pnd_blk_d;
  logic                  pend_valid_q, pend_valid_d;

  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  tick_q, tick_d;

  logic                  slot_end, frame_end;
  logic [3:0]            nib;
  logic                  cur_on, cur_blk, cur_dp, hi_zero, blank, dead;
  logic [SEG_W-1:0]      lut_seg;

  // Single decoder shared by all digits, fed by the currently scanned nibble
  seg7_hex_lut u_lut (
    .nib_i   (nib),
    .seg_o_c (lut_seg)
  );

  // Scan timing, blink phase and tear-free active/pending set update
  always_comb begin
    slot_end     = (pre_q == PRE_W'(SCAN_DIV - 1));
    frame_end    = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    pre_d        = slot_end ? '0 : pre_q + PRE_W'(1);
    idx_d        = idx_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_on_d     = act_on_q;
    act_blk_d    = act_blk_q;
    pnd_val_d    = pnd_val_q;
    pnd_dp_d     = pnd_dp_q;
    pnd_on_d     = pnd_on_q;
    pnd_blk_d    = pnd_blk_q;
    pend_valid_d = pend_valid_q;

    if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    if (frame_end) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    if (load) begin
      pnd_val_d    = value_in;
      pnd_dp_d     = dp_in;
      pnd_on_d     = digit_on;
      pnd_blk_d    = blink_en;
      pend_valid_d = 1'b1;
    end

    // A load landing on the boundary cycle goes straight to the active set
    if (frame_end) begin
      pend_valid_d = 1'b0;
      if (load) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
        act_on_d  = digit_on;
        act_blk_d = blink_en;
      end else if (pend_valid_q) begin
        act_val_d = pnd_val_q;
        act_dp_d  = pnd_dp_q;
        act_on_d  = pnd_on_q;
        act_blk_d = pnd_blk_q;
      end
    end
  end

  // Digit select, blanking rules and next pin values for the current slot
  always_comb begin
    nib     = 4'h0;
    cur_on  = 1'b0;
    cur_blk = 1'b0;
    cur_dp  = 1'b0;
    hi_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib     = act_val_q[4*k +: 4];
        cur_on  = act_on_q[k];
        cur_blk = act_blk_q[k];
        cur_dp  = act_dp_q[k];
      end
      if ((IDX_W'(k) >= idx_q) && (act_val_q[4*k +: 4] != 4'h0)) hi_zero = 1'b0;
    end

    dead  = (pre_q < PRE_W'(DEAD_CYC));
    blank = !cur_on || (cur_blk && phase_q) || (lz_sup && (idx_q != '0) && hi_zero);

    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    sel_d  = '1;
    tick_d = frame_end;
    if (!dead) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!blank) begin
        seg_d = lut_seg;
        dp_d  = ~cur_dp;
      end
    end
  end

  // Counter and display-set state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_on_q     <= '0;
      act_blk_q    <= '0;
      pnd_val_q    <= '0;
      pnd_dp_q     <= '0;
      pnd_on_q     <= '0;
      pnd_blk_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_on_q     <= act_on_d;
      act_blk_q    <= act_blk_d;
      pnd_val_q    <= pnd_val_d;
      pnd_dp_q     <= pnd_dp_d;
      pnd_on_q     <= pnd_on_d;
      pnd_blk_q    <= pnd_blk_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Output pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      sel_q  <= '1;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed vector table, hand sequences for
// frame-boundary and reset corners, and random loads against a reference model.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned DC = 1;
  localparam int unsigned BF = 2;
  localparam int unsigned FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_on = '0;
  logic [3:0]  blink_en = '0;
  logic        lz_sup = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEAD_CYC     (DC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .digit_on   (digit_on),
    .blink_en   (blink_en),
    .lz_sup     (lz_sup),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  on;
    logic [3:0]  blk;
  } set_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  on;
    logic        lz;
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic [3:0]  edp;    // dp_out seen while digit k is selected
  } vec_t;

  set_t       act_m, pend_m;
  logic       pv_m;
  int         t;
  int         errors = 0;
  int         checks = 0;
  logic [6:0] lut [16];
  logic [6:0] cap_seg [ND];
  logic [3:0] cap_dp;
  vec_t       vecs [8];
  logic [3:0] walk [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
  endtask

  // One clock of stimulus: predict pins from the model, advance the model, compare
  task automatic step(input bit cap);
    int         pre, frame;
    logic [1:0] idx;
    logic [3:0] n;
    bit         phase, bnd, blank;
    logic [6:0] es;
    logic       ed;
    logic [3:0] esel;
    set_t       in;
    pre   = t % SD;
    idx   = 2'((t / SD) % ND);
    frame = t / FR;
    phase = ((frame / BF) % 2) == 1;
    bnd   = (t % FR) == (FR - 1);
    in    = {value_in, dp_in, digit_on, blink_en};
    es = 7'h7F; ed = 1'b1; esel = 4'hF;
    if (pre >= DC) begin
      esel  = ~(4'(1) << idx);
      n     = 4'(act_m.val >> (4 * idx));
      blank = !act_m.on[idx] || (act_m.blk[idx] && phase) ||
              (lz_sup && idx != 0 && (act_m.val >> (4 * idx)) == 16'h0);
      if (!blank) begin
        es = lut[n];
        ed = ~act_m.dp[idx];
      end
    end
    if (load) begin
      if (bnd) begin act_m = in; pv_m = 1'b0; end
      else begin pend_m = in; pv_m = 1'b1; end
    end else if (bnd) begin
      if (pv_m) act_m = pend_m;
      pv_m = 1'b0;
    end
    @(posedge clk);
    #1;
    check("pins", 32'({seg_out, dp_out, dig_sel, frame_tick}), 32'({es, ed, esel, bnd}));
    if (cap) begin
      for (int k = 0; k < ND; k++) begin
        if (dig_sel == ~(4'(1) << k)) begin
          cap_seg[k] = seg_out;
          cap_dp[k]  = dp_out;
        end
      end
    end
    t++;
  endtask

  task automatic capture_frame();
    for (int k = 0; k < ND; k++) cap_seg[k] = 7'h55;
    cap_dp = 'x;
    while ((t % FR) != 0) step(1'b0);
    for (int c = 0; c < FR; c++) step(1'b1);
  endtask

  task automatic load_set(input logic [15:0] v, input logic [3:0] d, input logic [3:0] o,
                          input logic [3:0] b);
    value_in = v; dp_in = d; digit_on = o; blink_en = b;
    load = 1'b1;
    step(1'b0);
    load = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    check("reset_async", 32'({seg_out, dp_out, dig_sel, frame_tick}), 32'({7'h7F, 1'b1, 4'hF, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'({seg_out, dp_out, dig_sel, frame_tick}), 32'({7'h7F, 1'b1, 4'hF, 1'b0}));
    rst_n = 1'b1;
    t = 0; act_m = '0; pend_m = '0; pv_m = 1'b0;
  endtask

  initial begin
    logic [15:0] tmp;
    int          fr;

    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    walk = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    vecs[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vecs[1] = '{16'h0070, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF};
    vecs[2] = '{16'h0000, 4'hF, 4'hF, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hE};
    vecs[3] = '{16'h0000, 4'h0, 4'hF, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
    vecs[4] = '{16'h89CD, 4'h4, 4'hF, 1'b0, {7'h00, 7'h10, 7'h46, 7'h21}, 4'hB};
    vecs[5] = '{16'h3456, 4'hF, 4'hA, 1'b0, {7'h30, 7'h7F, 7'h12, 7'h7F}, 4'h5};
    vecs[6] = '{16'h0B0E, 4'h0, 4'hF, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h06}, 4'hF};
    vecs[7] = '{16'h0F00, 4'hF, 4'hF, 1'b0, {7'h40, 7'h0E, 7'h40, 7'h40}, 4'h0};

    do_reset();

    // First frame after reset: dig_sel walk with one dead cycle per slot
    for (int c = 0; c < 16; c++) begin
      step(1'b0);
      check($sformatf("walk%0d", c), 32'(dig_sel), 32'(walk[c]));
    end

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      lz_sup = vecs[i].lz;
      load_set(vecs[i].val, vecs[i].dp, vecs[i].on, 4'h0);
      capture_frame();
      for (int k = 0; k < ND; k++)
        check($sformatf("vec%0d_seg%0d", i, k), 32'(cap_seg[k]), 32'(vecs[i].segs[7*k +: 7]));
      check($sformatf("vec%0d_dp", i), 32'(cap_dp), 32'(vecs[i].edp));
    end
    lz_sup = 1'b0;

    // Blink on digit 0 only: blank in phase-1 frames, digit 1 steady
    load_set(16'h1234, 4'h0, 4'hF, 4'h1);
    for (int f = 0; f < 4; f++) begin
      capture_frame();
      fr = t / FR - 1;
      check($sformatf("blink_f%0d_d0", f), 32'(cap_seg[0]),
            32'((((fr / BF) % 2) == 1) ? 7'h7F : 7'h19));
      check($sformatf("blink_f%0d_d1", f), 32'(cap_seg[1]), 32'(7'h30));
    end

    // Two loads mid-frame: the last one wins
    while ((t % FR) != 3) step(1'b0);
    load_set(16'h1111, 4'h0, 4'hF, 4'h0);
    load_set(16'h2222, 4'h0, 4'hF, 4'h0);
    capture_frame();
    for (int k = 0; k < ND; k++)
      check($sformatf("lastwins_seg%0d", k), 32'(cap_seg[k]), 32'(7'h24));

    // Load on the boundary cycle applies to the frame that starts next cycle
    while ((t % FR) != (FR - 1)) step(1'b0);
    load_set(16'h5555, 4'h0, 4'hF, 4'h0);
    check("bnd_load_aligned", 32'(t % FR), 32'(0));
    capture_frame();
    for (int k = 0; k < ND; k++)
      check($sformatf("bndload_seg%0d", k), 32'(cap_seg[k]), 32'(7'h12));

    // Reset mid-slot with a pending load: pending is discarded, active cleared
    while ((t % FR) != 5) step(1'b0);
    load_set(16'h7777, 4'h0, 4'hF, 4'h0);
    check("pre_reset_lit", 32'(seg_out), 32'(7'h12));
    do_reset();
    for (int f = 0; f < 2; f++) begin
      capture_frame();
      for (int k = 0; k < ND; k++)
        check($sformatf("postrst_f%0d_seg%0d", f, k), 32'(cap_seg[k]), 32'(7'h7F));
      check($sformatf("postrst_f%0d_dp", f), 32'(cap_dp), 32'(4'hF));
    end

    // Random loads, blink and live lz_sup against the model
    for (int c = 0; c < 480; c++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        tmp      = 16'($urandom());
        value_in = tmp >> (4 * $urandom_range(0, 4));
        dp_in    = 4'($urandom());
        digit_on = 4'($urandom());
        blink_en = 4'($urandom());
      end
      if ($urandom_range(0, 19) == 0) lz_sup = ~lz_sup;
      step(1'b0);
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
